// File: rtl/led_seq_pkg.sv
// Shared definitions for led_sequencer: pattern mode encodings and bounce direction constants.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE and flags TICK while sitting on the terminal count.
module tick_gen #(
    parameter int unsigned PRESCALE = 250
) (
    input  logic CLK50MHZ,
    input  logic RESET,
    input  logic EN,
    input  logic CLR,
    output logic TICK
);

    logic [31:0] count_reg;

    always_ff @(posedge CLK50MHZ or posedge RESET) begin
        if (RESET) begin
            count_reg <= '0;
        end else if (CLR) begin
            count_reg <= '0;
        end else if (EN) begin
            if (count_reg == PRESCALE) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

    // Combinational so the parent can advance on the same edge that wraps the count.
    assign TICK = EN && (count_reg == PRESCALE);

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: up/down count, walking one and bounce patterns advanced by a prescaled tick.
// Optional LED_SEQ_STEP_EN macro adds HOLD/STEP inputs for manual single-stepping.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned PRESCALE = 250
) (
    input  logic             CLK50MHZ,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       MODE,
`ifdef LED_SEQ_STEP_EN
    input  logic             HOLD,
    input  logic             STEP,
`endif
    output logic [WIDTH-1:0] LED,
    output logic             TICK
);

    mode_t            mode_reg;
    mode_t            mode_in;
    logic             dir_reg;
    logic             dir_next;
    logic [WIDTH-1:0] led_reg;
    logic [WIDTH-1:0] led_next;
    logic [WIDTH-1:0] seed;
    logic             tick_reg;
    logic             pre_en;
    logic             pre_step;
    logic             mode_change;
    logic             step;

    assign mode_in     = mode_t'(MODE);
    assign mode_change = (mode_reg != mode_in);

`ifdef LED_SEQ_STEP_EN
    logic [1:0] step_sync_reg;
    logic       step_prev_reg;
    logic       step_rise;

    always_ff @(posedge CLK50MHZ or posedge RESET) begin
        if (RESET) begin
            step_sync_reg <= '0;
            step_prev_reg <= 1'b0;
        end else begin
            step_sync_reg <= {step_sync_reg[0], STEP};
            step_prev_reg <= step_sync_reg[1];
        end
    end

    assign step_rise = step_sync_reg[1] & ~step_prev_reg;
    assign pre_en    = ENABLE & ~HOLD;
    assign step      = ENABLE & ~mode_change & (HOLD ? step_rise : pre_step);
`else
    assign pre_en    = ENABLE;
    assign step      = ENABLE & ~mode_change & pre_step;
`endif

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .CLK50MHZ (CLK50MHZ),
        .RESET    (RESET),
        .EN       (pre_en),
        .CLR      (mode_change),
        .TICK     (pre_step)
    );

    always_comb begin
        seed = '0;
        case (mode_in)
            MODE_UP:   seed = '0;
            MODE_DOWN: seed = '1;
            default:   seed = WIDTH'(1);
        endcase
    end

    // Bounce reverses when leaving an endpoint, so each endpoint is shown for exactly one step.
    always_comb begin
        led_next = led_reg;
        dir_next = dir_reg;
        case (mode_reg)
            MODE_UP:   led_next = led_reg + WIDTH'(1);
            MODE_DOWN: led_next = led_reg - WIDTH'(1);
            MODE_WALK: led_next = {led_reg[WIDTH-2:0], led_reg[WIDTH-1]};
            MODE_BOUNCE: begin
                if (dir_reg == DIR_LEFT) begin
                    if (led_reg[WIDTH-1]) begin
                        led_next = led_reg >> 1;
                        dir_next = DIR_RIGHT;
                    end else begin
                        led_next = led_reg << 1;
                    end
                end else begin
                    if (led_reg[0]) begin
                        led_next = led_reg << 1;
                        dir_next = DIR_LEFT;
                    end else begin
                        led_next = led_reg >> 1;
                    end
                end
            end
            default: led_next = led_reg;
        endcase
    end

    // A mode change reloads the seed even while ENABLE is low, so the new pattern starts clean.
    always_ff @(posedge CLK50MHZ or posedge RESET) begin
        if (RESET) begin
            led_reg  <= '0;
            tick_reg <= 1'b0;
            dir_reg  <= DIR_LEFT;
            mode_reg <= MODE_UP;
        end else begin
            mode_reg <= mode_in;
            tick_reg <= step;
            if (mode_change) begin
                led_reg <= seed;
                dir_reg <= DIR_LEFT;
            end else if (step) begin
                led_reg <= led_next;
                dir_reg <= dir_next;
            end
        end
    end

    assign LED  = led_reg;
    assign TICK = tick_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (WIDTH=8, PRESCALE=3): vector table plus multi-cycle sequences.
module tb_led_sequencer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic [7:0] led;
    logic       tick;
`ifdef LED_SEQ_STEP_EN
    logic       hold;
    logic       step_in;
`endif

    int n_vec;
    int n_err;

    led_sequencer #(
        .WIDTH    (8),
        .PRESCALE (3)
    ) dut (
        .CLK50MHZ (clk),
        .RESET    (rst),
        .ENABLE   (enable),
        .MODE     (mode),
`ifdef LED_SEQ_STEP_EN
        .HOLD     (hold),
        .STEP     (step_in),
`endif
        .LED      (led),
        .TICK     (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] led;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [1:0] m,
                       input logic [7:0] l, input logic t);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.led = l; v.tick = t;
        vecs.push_back(v);
    endtask

    // One prescaled step: three quiet cycles then the advancing edge.
    task automatic add_step(input logic [1:0] m, input logic [7:0] prev, input logic [7:0] nxt);
        for (int k = 0; k < 3; k++) add(1'b0, 1'b1, m, prev, 1'b0);
        add(1'b0, 1'b1, m, nxt, 1'b1);
    endtask

    task automatic check(input string name, input logic [7:0] exp_led, input logic exp_tick);
        n_vec++;
        if (led !== exp_led || tick !== exp_tick) begin
            n_err++;
            $display("FAIL %s: got LED=%h TICK=%b, expected LED=%h TICK=%b",
                     name, led, tick, exp_led, exp_tick);
        end else begin
            $display("ok   %s: LED=%h TICK=%b", name, led, tick);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] walk_seq[7];
    logic [7:0] bounce_seq[15];
    logic [7:0] prev;
    logic [7:0] exp_led;
    int         ticks;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; enable = 1'b0; mode = 2'd0;
`ifdef LED_SEQ_STEP_EN
        hold = 1'b0; step_in = 1'b0;
`endif
        walk_seq   = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // ---------------- vector table ----------------
        add(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        add_step(2'd0, 8'h00, 8'h01);
        add_step(2'd0, 8'h01, 8'h02);
        add(1'b0, 1'b1, 2'd0, 8'h02, 1'b0);
        for (int k = 0; k < 10; k++) add(1'b0, 1'b0, 2'd0, 8'h02, 1'b0);
        add(1'b0, 1'b1, 2'd0, 8'h02, 1'b0);
        add(1'b0, 1'b1, 2'd0, 8'h02, 1'b0);
        add(1'b0, 1'b1, 2'd0, 8'h03, 1'b1);
        add(1'b0, 1'b1, 2'd1, 8'hFF, 1'b0);
        add_step(2'd1, 8'hFF, 8'hFE);
        add_step(2'd1, 8'hFE, 8'hFD);
        for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 2'd1, 8'hFD, 1'b0);
        add(1'b0, 1'b1, 2'd2, 8'h01, 1'b0);
        add_step(2'd2, 8'h01, 8'h02);
        prev = 8'h02;
        for (int k = 0; k < 7; k++) begin
            add_step(2'd2, prev, walk_seq[k]);
            prev = walk_seq[k];
        end
        add(1'b0, 1'b1, 2'd3, 8'h01, 1'b0);
        prev = 8'h01;
        for (int k = 0; k < 15; k++) begin
            add_step(2'd3, prev, bounce_seq[k]);
            prev = bounce_seq[k];
        end

        foreach (vecs[i]) begin
            rst = vecs[i].rst; enable = vecs[i].en; mode = vecs[i].mode;
            edge_wait();
            check($sformatf("vec%0d", i), vecs[i].led, vecs[i].tick);
        end

        // ---------------- async reset, mid-step reset, seed after release ----------------
        rst = 1'b1; mode = 2'd0; enable = 1'b1;
        edge_wait();
        rst = 1'b0;
        repeat (4) edge_wait();
        check("pre_reset_led", 8'h01, 1'b1);
        repeat (3) edge_wait();
        check("step_pending", 8'h01, 1'b0);
        rst = 1'b1; mode = 2'd1;
        #1;
        check("async_reset", 8'h00, 1'b0);
        edge_wait();
        check("reset_mid_step", 8'h00, 1'b0);
        rst = 1'b0;
        edge_wait();
        check("seed_after_release", 8'hFF, 1'b0);

        // ---------------- mode 0 full wrap ----------------
        rst = 1'b1; mode = 2'd0;
        edge_wait();
        rst = 1'b0;
        exp_led = 8'h00;
        for (int s = 1; s <= 256; s++) begin
            repeat (3) begin
                edge_wait();
                check($sformatf("up_wait%0d", s), exp_led, 1'b0);
            end
            exp_led = exp_led + 8'h01;
            edge_wait();
            check($sformatf("up_step%0d", s), exp_led, 1'b1);
        end
        check("up_wrapped_to_zero", 8'h00, tick);

        // ---------------- mode 1 full wrap ----------------
        mode = 2'd1;
        edge_wait();
        check("down_seed", 8'hFF, 1'b0);
        exp_led = 8'hFF;
        for (int s = 1; s <= 256; s++) begin
            repeat (3) begin
                edge_wait();
                check($sformatf("dn_wait%0d", s), exp_led, 1'b0);
            end
            exp_led = exp_led - 8'h01;
            edge_wait();
            check($sformatf("dn_step%0d", s), exp_led, 1'b1);
        end

`ifdef LED_SEQ_STEP_EN
        // ---------------- manual stepping under HOLD ----------------
        rst = 1'b1; mode = 2'd0; enable = 1'b1; hold = 1'b1; step_in = 1'b0;
        edge_wait();
        rst = 1'b0;
        ticks = 0;
        for (int p = 0; p < 3; p++) begin
            step_in = 1'b1;
            repeat (3) begin edge_wait(); ticks += int'(tick); end
            step_in = 1'b0;
            repeat (5) begin edge_wait(); ticks += int'(tick); end
        end
        repeat (10) begin edge_wait(); ticks += int'(tick); end
        check("hold_led", 8'h03, 1'b0);
        n_vec++;
        if (ticks != 3) begin
            n_err++;
            $display("FAIL hold_ticks: got %0d pulses, expected 3", ticks);
        end else begin
            $display("ok   hold_ticks: %0d pulses", ticks);
        end
        hold = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
